// File: rtl/dsd_pkg.sv
// dsd_pkg: shared types and helpers for the DSD receive path.
package dsd_pkg;
  typedef enum logic {HUNT, RUN} dsd_rx_state_t;
  function automatic int cnt_w(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction
endpackage

// File: rtl/dsd_rx_fifo.sv
// dsd_rx_fifo: 2-entry head/tail FIFO; head register drives the output directly.
module dsd_rx_fifo #(
  parameter int W = 32
) (
  input  logic         bclk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  logic [W-1:0] r_head, r_tail;
  logic [1:0]   r_cnt;
  logic         w_push, w_pop;
  assign w_pop   = pop_i && r_cnt != 2'd0;
  assign w_push  = push_i && (r_cnt != 2'd2 || w_pop);
  assign dout_o  = r_head;
  assign full_o  = r_cnt == 2'd2;
  assign empty_o = r_cnt == 2'd0;
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push && (r_cnt == 2'd0 || (w_pop && r_cnt == 2'd1))) r_head <= din_i;
      else if (w_pop && r_cnt == 2'd2) r_head <= r_tail;
      if (w_push && (r_cnt == 2'd2 || (r_cnt == 2'd1 && !w_pop))) r_tail <= din_i;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
endmodule

// File: rtl/dsd_rx.sv
// dsd_rx: DSD stereo serial receiver with frame-sync alignment and a 2-word output buffer.
module dsd_rx
  import dsd_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          bclk,
  input  logic          rst_n,
  input  logic          sync_i,
  input  logic          ldata_i,
  input  logic          rdata_i,
  output logic [DW-1:0] ldata_o,
  output logic [DW-1:0] rdata_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic          locked_o,
  output logic          resync_o,
  output logic          overrun_o,
  input  logic          clr_i
);
  localparam int BW = cnt_w(DW);
  localparam logic [BW-1:0] LAST = BW'(DW - 1);
  dsd_rx_state_t r_state, w_next;
  logic [BW-1:0] r_bcnt, w_bcnt;
  logic [DW-1:0] r_lsh, r_rsh, w_lsh, w_rsh;
  logic          w_mis, w_push, w_full, w_empty, w_drop;
  logic          r_resync, r_overrun;
  always_comb begin
    w_next = r_state;
    w_bcnt = r_bcnt;
    w_lsh  = {r_lsh[DW-2:0], ldata_i};
    w_rsh  = {r_rsh[DW-2:0], rdata_i};
    w_mis  = 1'b0;
    w_push = 1'b0;
    if (r_state == HUNT) begin
      w_lsh = sync_i ? DW'(ldata_i) : r_lsh;
      w_rsh = sync_i ? DW'(rdata_i) : r_rsh;
      w_bcnt = sync_i ? BW'(1) : r_bcnt;
      w_next = sync_i ? RUN : HUNT;
    end else if (sync_i && r_bcnt != '0) begin
      // misaligned sync: drop the partial word and restart on this bit as MSB
      w_mis  = 1'b1;
      w_lsh  = DW'(ldata_i);
      w_rsh  = DW'(rdata_i);
      w_bcnt = BW'(1);
    end else begin
      w_push = r_bcnt == LAST;
      w_bcnt = w_push ? '0 : r_bcnt + 1'b1;
    end
  end
  assign w_drop    = w_push && w_full && !ready_i;
  assign valid_o   = !w_empty;
  assign locked_o  = r_state == RUN;
  assign resync_o  = r_resync;
  assign overrun_o = r_overrun;
  always_ff @(posedge bclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= HUNT;
      r_bcnt    <= '0;
      r_lsh     <= '0;
      r_rsh     <= '0;
      r_resync  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_bcnt    <= w_bcnt;
      r_lsh     <= w_lsh;
      r_rsh     <= w_rsh;
      r_resync  <= w_mis;
      r_overrun <= w_drop ? 1'b1 : (clr_i ? 1'b0 : r_overrun);
    end
  end
  dsd_rx_fifo #(.W(2 * DW)) u_fifo (
    .bclk    (bclk),
    .rst_n   (rst_n),
    .push_i  (w_push),
    .pop_i   (ready_i),
    .din_i   ({w_lsh, w_rsh}),
    .dout_o  ({ldata_o, rdata_o}),
    .full_o  (w_full),
    .empty_o (w_empty)
  );
endmodule

// File: tb/tb_dsd_rx.sv
// tb_dsd_rx: directed stimulus with a queue scoreboard checked by a handshake monitor.
module tb_dsd_rx;
  localparam int DW = 16;
  logic          bclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sync_i = 1'b0, ldata_i = 1'b0, rdata_i = 1'b0, ready_i = 1'b1, clr_i = 1'b0;
  logic [DW-1:0] ldata_o, rdata_o;
  logic          valid_o, locked_o, resync_o, overrun_o;
  logic [31:0]   q[$];
  int            total = 0, bad = 0, n_resync = 0, base;
  dsd_rx #(.DW(DW)) dut (
    .bclk      (bclk),
    .rst_n     (rst_n),
    .sync_i    (sync_i),
    .ldata_i   (ldata_i),
    .rdata_i   (rdata_i),
    .ldata_o   (ldata_o),
    .rdata_o   (rdata_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .locked_o  (locked_o),
    .resync_o  (resync_o),
    .overrun_o (overrun_o),
    .clr_i     (clr_i)
  );
  always #5 bclk = ~bclk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge bclk) begin
    if (rst_n) begin
      if (resync_o) n_resync++;
      if (valid_o && ready_i) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious word: got %h/%h expected none", ldata_o, rdata_o);
        end else begin
          logic [31:0] e;
          e = q.pop_front();
          chk("ldata", {16'h0, ldata_o}, {16'h0, e[31:16]});
          chk("rdata", {16'h0, rdata_o}, {16'h0, e[15:0]});
        end
      end
    end
  end
  task automatic drive(input logic s, input logic l, input logic r, input logic c);
    sync_i = s; ldata_i = l; rdata_i = r; clr_i = c;
    @(posedge bclk); #1;
  endtask
  task automatic send_word(input logic [15:0] l, input logic [15:0] r, input logic s);
    for (int i = 0; i < DW; i++) drive(s && i == 0, l[15-i], r[15-i], 1'b0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic do_reset();
    sync_i = 0; ldata_i = 0; rdata_i = 0; clr_i = 0;
    rst_n = 0;
    repeat (2) @(posedge bclk);
    #1 rst_n = 1;
  endtask
  initial begin
    logic [15:0] fl [4];
    fl = '{16'h0001, 16'h8000, 16'hFFFF, 16'h0000};
    @(posedge bclk); #1;
    chk("rst valid", {31'h0, valid_o}, 0);
    chk("rst locked", {31'h0, locked_o}, 0);
    chk("rst outs", {ldata_o, rdata_o}, 0);
    chk("rst flags", {30'h0, resync_o, overrun_o}, 0);
    do_reset();
    send_word(16'h5555, 16'h5555, 1'b0);
    chk("hunt ignores", {30'h0, locked_o, valid_o}, 0);
    q.push_back({16'hA5C3, 16'h1234});
    for (int i = 0; i < DW; i++) begin
      drive(i == 0, 1'(16'hA5C3 >> (15 - i)), 1'(16'h1234 >> (15 - i)), 1'b0);
      if (i == 0) chk("locked after sync", {31'h0, locked_o}, 1);
      if (i == DW - 2) chk("valid before lat", {31'h0, valid_o}, 0);
    end
    chk("valid at lat", {31'h0, valid_o}, 1);
    chk("head word", {ldata_o, rdata_o}, {16'hA5C3, 16'h1234});
    for (int k = 0; k < 4; k++) begin
      q.push_back({fl[k], ~fl[k]});
      send_word(fl[k], ~fl[k], 1'b0);
    end
    chk("freerun locked", {31'h0, locked_o}, 1);
    base = n_resync;
    q.push_back({16'h1111, 16'h2222});
    send_word(16'h1111, 16'h2222, 1'b1);
    for (int i = 0; i < 5; i++) drive(1'b0, i[0], ~i[0], 1'b0);
    q.push_back({16'hBEEF, 16'h4321});
    send_word(16'hBEEF, 16'h4321, 1'b1);
    idle(2);
    chk("resync pulses", n_resync - base, 1);
    chk("queue after misalign", q.size(), 0);
    do_reset();
    ready_i = 0;
    q.push_back({16'hC001, 16'h0C01});
    q.push_back({16'hC002, 16'h0C02});
    send_word(16'hC001, 16'h0C01, 1'b1);
    send_word(16'hC002, 16'h0C02, 1'b0);
    send_word(16'hC003, 16'h0C03, 1'b0);
    chk("overrun set", {31'h0, overrun_o}, 1);
    chk("held head", {ldata_o, rdata_o}, {16'hC001, 16'h0C01});
    for (int i = 0; i < DW; i++) begin
      drive(1'b0, 1'b1, 1'b0, i == 0 || i == DW - 1);
      if (i == 0) chk("clr alone", {31'h0, overrun_o}, 0);
    end
    chk("set beats clr", {31'h0, overrun_o}, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr next cycle", {31'h0, overrun_o}, 0);
    ready_i = 1;
    idle(3);
    chk("drained valid", {31'h0, valid_o}, 0);
    chk("drained queue", q.size(), 0);
    do_reset();
    ready_i = 0;
    send_word(16'h3C3C, 16'hC3C3, 1'b1);
    for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
    chk("buffered before rst", {31'h0, valid_o}, 1);
    rst_n = 0;
    #2;
    chk("async rst data", {ldata_o, rdata_o}, 0);
    chk("async rst flags", {28'h0, valid_o, locked_o, resync_o, overrun_o}, 0);
    @(posedge bclk); #1 rst_n = 1;
    ready_i = 1;
    send_word(16'h7777, 16'h7777, 1'b0);
    chk("no sync after rst", {30'h0, locked_o, valid_o}, 0);
    q.push_back({16'h0F0F, 16'hF0F0});
    send_word(16'h0F0F, 16'hF0F0, 1'b1);
    idle(2);
    chk("final queue", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
